multicycle_control_unit: RTL

Parametrised successor to the single-cycle control unit: a registered FSM that sequences each MIPS instruction through fetch, execute and memory phases. It waits on the ihit/dhit handshakes and latches the instruction word. It produces per-phase datapath controls, including PC enable and register write strobes. It adds behaviour the combinational unit lacks: memory-wait watchdog, sticky halt, illegal-opcode fault and optional performance counters. It sits between the caches (ihit/dhit) and the datapath.

---
 rtl/multicycle_control_unit.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences FETCH/EXEC/MEM with a memory-wait watchdog and sticky halt/fault.
// Define CU_PERF_EN to add the saturating instr_cnt/stall_cnt performance counters.
module multicycle_control_unit #(
    parameter int unsigned TIMEOUT = 16
`ifdef CU_PERF_EN
   ,parameter int unsigned CNT_W   = 32
`endif
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] instr,
    input  logic        equal,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        pcEN,
    output logic [1:0]  pc_src,
    output logic        regWEN,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        ext_op,
    output logic        upper_imm,
    output logic [3:0]  alu_op,
    output logic [31:0] ir,
    output logic        halt,
    output logic        fault
`ifdef CU_PERF_EN
   ,output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_SLL  = 4'h0;
    localparam logic [3:0] ALU_SRL  = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'hA;
    localparam logic [3:0] ALU_SLTU = 4'hB;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALTED, FAULT} state_t;

    state_t              state, nextState;
    logic [WAIT_W-1:0]   waitCnt, nextWait;
    logic                stall;
    logic                illegal;
    logic                atLimit;
    logic                isLoad;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          rDec;

    // R-type funct to {valid, aluop}; JR is handled separately as it has no ALU result.
    function automatic logic [4:0] rtypeDecode(input logic [5:0] fn);
        case (fn)
            FN_SLL:          return {1'b1, ALU_SLL};
            FN_SRL:          return {1'b1, ALU_SRL};
            FN_ADD, FN_ADDU: return {1'b1, ALU_ADD};
            FN_SUB, FN_SUBU: return {1'b1, ALU_SUB};
            FN_AND:          return {1'b1, ALU_AND};
            FN_OR:           return {1'b1, ALU_OR};
            FN_XOR:          return {1'b1, ALU_XOR};
            FN_NOR:          return {1'b1, ALU_NOR};
            FN_SLT:          return {1'b1, ALU_SLT};
            FN_SLTU:         return {1'b1, ALU_SLTU};
            default:         return 5'b0;
        endcase
    endfunction

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rDec    = rtypeDecode(funct);
    assign isLoad  = (opcode == OP_LW);
    assign atLimit = (TIMEOUT != 0) && (waitCnt == WAIT_W'(LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            waitCnt <= '0;
            ir      <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
            if (state == FETCH && ihit) begin
                ir <= instr;
            end
        end
    end

    // Next state and per-phase controls; everything is quiet unless the phase drives it.
    always_comb begin
        nextState  = state;
        stall      = 1'b0;
        illegal    = 1'b0;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        pcEN       = 1'b0;
        pc_src     = PC_SEQ;
        regWEN     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        upper_imm  = 1'b0;
        alu_op     = '0;
        halt       = 1'b0;
        fault      = 1'b0;

        unique case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    nextState = EXEC;
                end else begin
                    stall = 1'b1;
                    if (atLimit) nextState = FAULT;
                end
            end
            EXEC: begin
                nextState = FETCH;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pcEN   = 1'b1;
                            pc_src = PC_REG;
                        end else if (rDec[4]) begin
                            pcEN    = 1'b1;
                            regWEN  = 1'b1;
                            reg_dst = DST_RD;
                            alu_op  = rDec[3:0];
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_J: begin
                        pcEN   = 1'b1;
                        pc_src = PC_JUMP;
                    end
                    OP_JAL: begin
                        pcEN    = 1'b1;
                        pc_src  = PC_JUMP;
                        regWEN  = 1'b1;
                        reg_dst = DST_RA;
                    end
                    OP_BEQ, OP_BNE: begin
                        pcEN   = 1'b1;
                        alu_op = ALU_SUB;
                        pc_src = ((opcode == OP_BEQ) == equal) ? PC_BRANCH : PC_SEQ;
                    end
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                        pcEN      = 1'b1;
                        regWEN    = 1'b1;
                        alu_src   = 1'b1;
                        ext_op    = !(opcode inside {OP_ANDI, OP_ORI, OP_XORI});
                        upper_imm = (opcode == OP_LUI);
                        case (opcode)
                            OP_SLTI:  alu_op = ALU_SLT;
                            OP_SLTIU: alu_op = ALU_SLTU;
                            OP_ANDI:  alu_op = ALU_AND;
                            OP_ORI:   alu_op = ALU_OR;
                            OP_XORI:  alu_op = ALU_XOR;
                            default:  alu_op = ALU_ADD;
                        endcase
                    end
                    OP_LW, OP_SW: begin
                        alu_src   = 1'b1;
                        nextState = MEM;
                    end
                    OP_HALT: begin
                        ext_op    = 1'b0;
                        alu_op    = '0;
                        nextState = HALTED;
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
                    ext_op    = 1'b0;
                    alu_op    = '0;
                    nextState = FAULT;
                end
            end
            MEM: begin
                alu_src = 1'b1;
                ext_op  = 1'b1;
                alu_op  = ALU_ADD;
                dmemREN = isLoad;
                dmemWEN = !isLoad;
                if (dhit) begin
                    pcEN       = 1'b1;
                    regWEN     = isLoad;
                    mem_to_reg = isLoad;
                    nextState  = FETCH;
                end else begin
                    stall = 1'b1;
                    if (atLimit) nextState = FAULT;
                end
            end
            HALTED: halt = 1'b1;
            FAULT:  fault = 1'b1;
            default: nextState = IDLE;
        endcase

        if (nextState != state) begin
            nextWait = '0;
        end else if (stall) begin
            nextWait = waitCnt + WAIT_W'(1);
        end else begin
            nextWait = waitCnt;
        end
    end

`ifdef CU_PERF_EN
    // Saturating retired-instruction and memory-stall counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pcEN && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_W'(1);
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
